acc_control_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 16-bit accumulator computer; sits upstream of the ALU and main memory.
- Owns the architectural PC, IR, MBR and AC registers.
- Issues memory read/write requests over a req/ack handshake and drives the ALU opcode using the ALU's 4-bit encoding.
- Captures the ALU result back into AC.

---
 rtl/acc_isa_pkg.sv | 48 ++++
 rtl/acc_mem_port.sv | 54 +++++
 rtl/acc_control_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_acc_control_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_isa_pkg.sv
// Shared ISA definitions for the accumulator computer: instruction opcodes,
// the ALU opcode encoding, SKIPCOND condition codes and the sequencer
// state enumeration.
package acc_isa_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;

  localparam logic [1:0] COND_NEG   = 2'b00;
  localparam logic [1:0] COND_ZERO  = 2'b01;
  localparam logic [1:0] COND_POS   = 2'b10;
  localparam logic [1:0] COND_NEVER = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_HALTED
  } state_t;

  // Instruction opcode to ALU opcode; non-ALU opcodes map to add.
  function automatic logic [3:0] alu_op_of(input logic [3:0] opc);
    case (opc)
      OP_SUBT: alu_op_of = ALU_SUB;
      OP_AND:  alu_op_of = ALU_AND;
      OP_OR:   alu_op_of = ALU_OR;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/acc_mem_port.sv
// Registered req/ack request port. A one-cycle start pulse loads the request
// (we, addr, wdata) and raises req; everything is held until the ack cycle.
// A start in the ack cycle issues the next request back-to-back.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   start, start_we/addr/wdata        request issue from the controller
//   mem_ack                           completion from memory
//   mem_req, mem_we, mem_addr, mem_wdata  registered request outputs
//   ack_valid                         ack qualified by an outstanding req
module acc_mem_port
  import acc_isa_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ack_valid
);

  // Acks arriving with no request outstanding (e.g. after reset) are dropped.
  assign ack_valid = mem_req & mem_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else if (start) begin
      mem_req <= 1'b1;
      mem_we  <= start_we;
    end else if (ack_valid) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // Address/data are only meaningful while mem_req is high.
  always_ff @(posedge clk) begin
    if (start) begin
      mem_addr  <= start_addr;
      mem_wdata <= start_wdata;
    end
  end

endmodule

// File: rtl/acc_control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator computer.
// Owns PC, IR, MBR and AC; reaches memory through acc_mem_port and drives
// the external combinational ALU.
// Ports:
//   clk, reset_n, run                 clock, async active-low reset, run level
//   mem_*                             req/ack memory port
//   alu_op, alu_a, alu_b, alu_result  ALU interface (a = AC, b = MBR)
//   pc, ac                            architectural state
//   halted, illegal, instr_done       status
module acc_control_sequencer
  import acc_isa_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              halted,
  output logic              illegal,
  output logic              instr_done
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
  logic illegal_q, illegal_d;

  logic              start, start_we, ack_valid, retire;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_wdata;

  logic [3:0]               opcode;
  logic [ADDR_W-1:0]        operand;
  logic signed [DATA_W-1:0] ac_s;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign ac_s    = ac_q;

  function automatic logic skip_taken(input logic [1:0] cc,
                                      input logic signed [DATA_W-1:0] a);
    case (cc)
      COND_NEG:  skip_taken = (a < 0);
      COND_ZERO: skip_taken = (a == 0);
      COND_POS:  skip_taken = (a > 0);
      default:   skip_taken = 1'b0;
    endcase
  endfunction

  acc_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_port (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_we   (start_we),
    .start_addr (start_addr),
    .start_wdata(start_wdata),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .ack_valid  (ack_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      illegal_q <= illegal_d;
    end
  end

  // The next fetch request is issued on the transition into FETCH so that
  // req is already high in the first FETCH cycle; its address is pc_d, which
  // already reflects a JUMP target or SKIPCOND increment.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mbr_d       = mbr_q;
    ac_d        = ac_q;
    illegal_d   = illegal_q;
    start       = 1'b0;
    start_we    = 1'b0;
    start_addr  = pc_q;
    start_wdata = ac_q;
    retire      = 1'b0;
    instr_done  = 1'b0;
    alu_op      = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          start   = 1'b1;
        end
      end
      S_FETCH: begin
        if (ack_valid) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT, OP_AND, OP_OR: begin
            state_d    = S_MEM_RD;
            start      = 1'b1;
            start_addr = operand;
          end
          OP_STORE: begin
            state_d    = S_MEM_WR;
            start      = 1'b1;
            start_we   = 1'b1;
            start_addr = operand;
          end
          OP_NOP: retire = 1'b1;
          OP_SKIP: begin
            if (skip_taken(ir_q[ADDR_W-1 -: 2], ac_s)) pc_d = pc_q + PC_ONE;
            retire = 1'b1;
          end
          OP_JUMP: begin
            pc_d   = operand;
            retire = 1'b1;
          end
          OP_CLEAR: begin
            ac_d   = '0;
            retire = 1'b1;
          end
          OP_HALT: begin
            instr_done = 1'b1;
            state_d    = S_HALTED;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALTED;
          end
        endcase
      end
      S_MEM_RD: begin
        if (ack_valid) begin
          mbr_d   = mem_rdata;
          state_d = S_WB;
        end
      end
      S_MEM_WR: begin
        if (ack_valid) retire = 1'b1;
      end
      S_WB: begin
        alu_op = alu_op_of(opcode);
        ac_d   = (opcode == OP_LOAD) ? mbr_q : alu_result;
        retire = 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // run is only sampled here and in IDLE.
    if (retire) begin
      instr_done = 1'b1;
      if (run) begin
        state_d    = S_FETCH;
        start      = 1'b1;
        start_we   = 1'b0;
        start_addr = pc_d;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  assign alu_a   = ac_q;
  assign alu_b   = mbr_q;
  assign pc      = pc_q;
  assign ac      = ac_q;
  assign halted  = (state_q == S_HALTED);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_acc_control_sequencer.sv
module tb_acc_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [11:0] pc;
  logic [15:0] ac;
  logic        halted, illegal, instr_done;

  // Memory / responder state
  logic [15:0] mem [0:4095];
  int          ack_dly = 1;
  int          cnt = 0;
  logic        resp_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic [11:0] cap_addr = '0;
  logic [15:0] cap_wd = '0;
  logic        cap_we = 1'b0;
  int          n_unstable = 0;
  logic [11:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  int          n_wr = 0;
  int          n_ret = 0;
  int          n_req_cyc = 0;

  int n_cmp = 0;
  int n_err = 0;
  int base_ret, base_req;

  assign mem_ack = resp_ack | force_ack;

  acc_control_sequencer #(.ADDR_W(12), .DATA_W(16), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc(pc), .ac(ac), .halted(halted), .illegal(illegal),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  // Memory responder: acks ack_dly cycles after a request is seen, and
  // tracks whether the request stays stable while waiting.
  always @(negedge clk) begin
    if (!reset_n) begin
      resp_ack = 1'b0;
      cnt = 0;
    end else if (resp_ack) begin
      resp_ack = 1'b0;
      cnt = 0;
    end else if (mem_req) begin
      cnt++;
      if (cnt == 1) begin
        cap_addr = mem_addr; cap_wd = mem_wdata; cap_we = mem_we;
      end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                   (mem_we && mem_wdata !== cap_wd)) begin
        n_unstable++;
      end
      if (cnt >= ack_dly) begin
        resp_ack = 1'b1;
        if (mem_we) begin
          wr_addr = mem_addr; wr_data = mem_wdata; n_wr++;
        end else begin
          mem_rdata = mem[mem_addr];
        end
      end
    end else begin
      cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (instr_done) n_ret++;
    if (mem_req) n_req_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h7000;
  endtask

  task automatic do_reset();
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    base_ret = n_ret;
  endtask

  task automatic wait_halt(input int maxc);
    for (int i = 0; i < maxc && !halted; i++) @(negedge clk);
  endtask

  task automatic wait_retire(input int k, input int maxc);
    for (int i = 0; i < maxc && (n_ret - base_ret) < k; i++) @(negedge clk);
  endtask

  task automatic load_add_store_prog();
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h7000;
    mem[12'h010] = 16'h0005; mem[12'h011] = 16'h0007;
  endtask

  initial begin
    // Reset state
    clear_mem();
    do_reset();
    chk("rst_pc", pc, 12'h000);
    chk("rst_ac", ac, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_done", instr_done, 1'b0);

    // LOAD/ADD/STORE/HALT, ack one cycle after req
    load_add_store_prog();
    ack_dly = 1;
    do_reset();
    run = 1'b1;
    wait_halt(200);
    chk("p1_halted", halted, 1'b1);
    chk("p1_ac", ac, 16'h000C);
    chk("p1_pc", pc, 12'h004);
    chk("p1_wr_addr", wr_addr, 12'h012);
    chk("p1_wr_data", wr_data, 16'h000C);
    chk("p1_retired", n_ret - base_ret, 4);
    chk("p1_illegal", illegal, 1'b0);

    // Same program, ack delayed 3 cycles
    load_add_store_prog();
    ack_dly = 3;
    wr_data = 16'h0000;
    do_reset();
    run = 1'b1;
    wait_halt(400);
    chk("p2_halted", halted, 1'b1);
    chk("p2_ac", ac, 16'h000C);
    chk("p2_pc", pc, 12'h004);
    chk("p2_wr_data", wr_data, 16'h000C);
    chk("p2_retired", n_ret - base_ret, 4);
    chk("p2_stable", n_unstable, 0);

    // SKIPCOND: 5 (AC<0, taken) -> 7 CLEAR -> 8 (AC>0, not) -> 9 (AC==0,
    // taken) -> 11 (never) -> 12 HALT
    clear_mem();
    mem[0] = 16'h1030; mem[1] = 16'h9005; mem[12'h030] = 16'hFFFF;
    mem[5] = 16'h8000; mem[7] = 16'hA000; mem[8] = 16'h8800;
    mem[9] = 16'h8400; mem[11] = 16'h8C00;
    ack_dly = 1;
    do_reset();
    run = 1'b1;
    wait_halt(400);
    chk("skip_halted", halted, 1'b1);
    chk("skip_pc", pc, 12'h00D);
    chk("skip_ac", ac, 16'h0000);
    chk("skip_retired", n_ret - base_ret, 8);

    // JUMP 0xFFF then NOP: PC wraps to 0
    clear_mem();
    mem[0] = 16'h9FFF; mem[12'hFFF] = 16'h0000;
    do_reset();
    run = 1'b1;
    wait_retire(1, 50);
    @(posedge clk);
    #1 run = 1'b0;
    wait_retire(2, 50);
    repeat (3) @(negedge clk);
    chk("wrap_pc", pc, 12'h000);
    chk("wrap_retired", n_ret - base_ret, 2);
    chk("wrap_req", mem_req, 1'b0);

    // JUMP 0xFFF then SUBT 0x020 with AC=0, M[0x020]=1
    mem[12'hFFF] = 16'h4020; mem[12'h020] = 16'h0001;
    do_reset();
    run = 1'b1;
    wait_retire(1, 50);
    @(posedge clk);
    #1 run = 1'b0;
    wait_retire(2, 50);
    repeat (3) @(negedge clk);
    chk("subt_ac", ac, 16'hFFFF);
    chk("subt_pc", pc, 12'h000);
    chk("subt_retired", n_ret - base_ret, 2);

    // Illegal opcode 0xC
    clear_mem();
    mem[0] = 16'hC000;
    do_reset();
    run = 1'b1;
    wait_halt(50);
    chk("ill_illegal", illegal, 1'b1);
    chk("ill_halted", halted, 1'b1);
    chk("ill_pc", pc, 12'h001);
    @(negedge clk);
    base_req = n_req_cyc;
    for (int i = 0; i < 8; i++) begin
      run = ~run;
      @(negedge clk);
    end
    chk("ill_no_req", n_req_cyc - base_req, 0);
    chk("ill_still_halted", halted, 1'b1);
    chk("ill_retired", n_ret - base_ret, 0);

    // Reset during a delayed fetch, then a late ack
    clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h0000;
    ack_dly = 1;
    do_reset();
    run = 1'b1;
    wait_retire(2, 50);
    ack_dly = 8;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_pc", pc, 12'h000);
    chk("arst_done", instr_done, 1'b0);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    base_ret = n_ret;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ack_req", mem_req, 1'b0);
    chk("late_ack_pc", pc, 12'h000);
    chk("late_ack_retired", n_ret - base_ret, 0);
    mem[0] = 16'h7000;
    ack_dly = 1;
    run = 1'b1;
    wait_halt(50);
    chk("refetch_halted", halted, 1'b1);
    chk("refetch_pc", pc, 12'h001);
    chk("refetch_retired", n_ret - base_ret, 1);
    chk("final_stable", n_unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
